codec_config_seq: RTL and testbench
===================================

CODEC_CONFIG_SEQ -- requirements
Module: codec_config_seq

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency.
REQ-002 SHALL have parameter I2C_HZ, default 100000, SCL bit rate; quarter-bit divider DIV = CLK_HZ/(4*I2C_HZ), giving 125 at the defaults.
REQ-003 SHALL have parameter MAX_RETRY, default 3, NACK retries allowed per word.
REQ-004 SHALL have port clk  input  1  system clock.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle pulse that runs the full init table.
REQ-007 SHALL have port vol_req  input  1  request a headphone volume write.
REQ-008 SHALL have port vol_data  input  7  headphone volume code.
REQ-009 SHALL have port vol_ack  output  1  one-cycle pulse when the volume write completes with ACK.
REQ-010 SHALL have port busy  output  1  transaction or sequence in progress.
REQ-011 SHALL have port done  output  1  high once the init table completes; held until reset or the next start.
REQ-012 SHALL have port error  output  1  sticky flag set when retries are exhausted; cleared by start or reset.
REQ-013 SHALL have port I2C_SCLK  output  1  I2C clock, push-pull.
REQ-014 SHALL have port I2C_SDAT  inout  1  I2C data, open-drain: drives 0 or Z, never 1.

Function
REQ-015 Each transaction SHALL be a 3-byte write: device address 8'h34, then {reg[6:0], data[8]}, then data[7:0], MSB first.
- Each byte is followed by one ACK bit sampled from I2C_SDAT.
REQ-016 Bit timing SHALL use a quarter tick every DIV clk cycles.
- Q0: SDA changes, SCL low.
- Q1: SCL rises.
- Q2: SDA sampled, SCL high.
- Q3: SCL falls.
REQ-017 START SHALL drive SDA high-to-low while SCL is high; STOP SHALL release SDA low-to-high while SCL is high.
- Idle bus: SCL=1, SDA released.
REQ-018 The sequencer FSM SHALL have states IDLE, LOAD, XFER, CHECK, NEXT, VOL, FAIL, with these transitions:
- IDLE -> LOAD on start.
- LOAD -> XFER.
- XFER -> CHECK when the STOP condition completes.
- CHECK -> NEXT on all ACKs; CHECK -> LOAD (retry) on any NACK while retries < MAX_RETRY; CHECK -> FAIL once retries are exhausted.
- NEXT -> LOAD while table index < 10; otherwise NEXT -> IDLE with done=1.
- FAIL -> IDLE with error=1 and done=0.
REQ-019 The init table SHALL contain 10 words written in this order: 0x1E00, 0x0017, 0x0217, 0x0479, 0x0679, 0x0812, 0x0A06, 0x0C00, 0x0E01, 0x1201.
- Contents: reset, line-in L/R, headphone L/R, analog path, digital path, power, 16-bit left-justified, active.
REQ-020 vol_req accepted in IDLE SHALL write 0x0580 | vol_data to register R2 and write the same value to R3 as a second transaction.
- vol_data is captured on accept.
- vol_ack pulses after both transactions ACK.
REQ-021 vol_req arriving while busy SHALL be held pending (latest vol_data wins) and serviced on return to IDLE.
REQ-022 start while busy SHALL be ignored.
- start and vol_req in the same IDLE cycle: start wins and the volume request stays pending.
REQ-023 A retry SHALL restart the whole 3-byte transaction with a fresh START; the retry counter resets on each new word.
REQ-024 An exhausted volume write SHALL set error and suppress vol_ack.
REQ-025 busy SHALL be 1 in every state except IDLE.

Reset
REQ-026 On reset_n=0 at a clk edge, all outputs SHALL reset as follows: SCL=1, SDA released, busy=0, done=0, error=0, vol_ack=0.
- FSM returns to IDLE; table index, retry count, pending volume and divider clear.
REQ-027 Reset mid-transaction SHALL abort immediately with no STOP generated; the next start resends from table entry 0.

Structure
REQ-028 Package codec_cfg_pkg SHALL hold the device address, the init table as a constant array, the table length, and the R2/R3 register numbers.
REQ-029 The sub-module i2c_write3 SHALL implement the byte/bit engine with interface go, word[15:0], busy, nack, SCL, SDA; the sequencer FSM SHALL stay in codec_config_seq.

Verification
REQ-030 Reset, then 20 idle cycles -> SCL=1, SDA=Z, busy=0, done=0, error=0.
REQ-031 start with an ACKing slave model and DIV=4 -> first frame 0x34/0x1E/0x00; 10 frames in table order; done=1 and busy=0 afterwards.
REQ-032 Slave NACKs the address byte of word 3 twice -> word 3 sent 3 times in total; sequence completes; error=0.
REQ-033 Slave NACKs every byte -> 4 attempts of word 0, then error=1, done=0, busy=0.
REQ-034 vol_req with vol_data=0x79 during init, then vol_data=0x60 -> after done, frames carry 0x05E0 then 0x07E0; single vol_ack pulse.
REQ-035 reset_n=0 asserted mid-byte of word 5 -> lines idle the next cycle; a new start begins at 0x1E00.

Source files
------------

// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg: shared constants and types for the audio codec configuration sequencer.
// Holds the codec device address, the power-up register table, the headphone volume
// register numbers, and the state types of the sequencer and the I2C write engine.
package codec_cfg_pkg;

    // 7-bit address 0x1A shifted left with the write bit (0) appended
    localparam logic [7:0] DEV_ADDR = 8'h34;

    localparam int unsigned TABLE_LEN = 10;
    localparam int unsigned IDX_W     = 4;

    // Each word is {reg[6:0], data[8:0]}
    localparam logic [15:0] INIT_TABLE [TABLE_LEN] = '{
        16'h1E00,   // reset
        16'h0017,   // line-in left
        16'h0217,   // line-in right
        16'h0479,   // headphone left
        16'h0679,   // headphone right
        16'h0812,   // analog path
        16'h0A06,   // digital path
        16'h0C00,   // power down control
        16'h0E01,   // 16-bit left-justified
        16'h1201    // active
    };

    localparam logic [6:0] REG_R2 = 7'd2;
    localparam logic [6:0] REG_R3 = 7'd3;

    // Bit 8 updates both channels together, bit 7 enables zero-cross switching
    localparam logic [8:0] VOL_FLAGS = 9'h180;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StXfer,
        StCheck,
        StNext,
        StVol,
        StFail
    } seq_state_e;

    typedef enum logic [1:0] {
        EngIdle,
        EngStart,
        EngData,
        EngStop
    } eng_state_e;

    function automatic logic [15:0] vol_word(input logic [6:0] reg_addr, input logic [6:0] vol);
        return {reg_addr, VOL_FLAGS | {2'b00, vol}};
    endfunction

endpackage

// File: rtl/i2c_write3.sv
// i2c_write3: single I2C master write of three bytes: DEV_ADDR, word[15:8], word[7:0].
// Each bit spans four quarter ticks (DIV clk cycles each):
//   Q0 SDA changes (SCL low), Q1 SCL rises, Q2 SDA sampled, Q3 SCL falls.
// Ports:
//   clk, reset_n  - system clock, synchronous active-low reset
//   go            - start a transaction (accepted only while idle)
//   word          - {reg, data} payload, captured on go
//   busy          - high from go until the STOP condition has completed
//   nack          - set if any of the three ACK bits read high; valid once busy falls
//   scl           - push-pull SCL
//   sda_low       - 1 pulls SDA low, 0 releases it
//   sda_in        - SDA line as seen on the pin
module i2c_write3
    import codec_cfg_pkg::*;
#(
    parameter int unsigned DIV = 125
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    input  logic [15:0] word,
    output logic        busy,
    output logic        nack,
    output logic        scl,
    output logic        sda_low,
    input  logic        sda_in
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    eng_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      quarter_q, quarter_d;
    logic [3:0]      bit_q, bit_d;
    logic [1:0]      byte_q, byte_d;
    logic [23:0]     shift_q, shift_d;
    logic            scl_q, scl_d;
    logic            sda_low_q, sda_low_d;
    logic            nack_q, nack_d;
    logic            sda_meta_q, sda_sync_q;
    logic            tick;
    logic            ack_bit;

    assign tick    = (state_q != EngIdle) && (cnt_q == CntMax);
    assign ack_bit = (bit_q == 4'd8);

    always_comb begin
        state_d   = state_q;
        cnt_d     = (state_q == EngIdle || tick) ? '0 : cnt_q + 1'b1;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        scl_d     = scl_q;
        sda_low_d = sda_low_q;
        nack_d    = nack_q;

        unique case (state_q)
            EngIdle: begin
                scl_d     = 1'b1;
                sda_low_d = 1'b0;
                if (go) begin
                    state_d   = EngStart;
                    shift_d   = {DEV_ADDR, word};
                    quarter_d = 2'd0;
                    bit_d     = 4'd0;
                    byte_d    = 2'd0;
                    nack_d    = 1'b0;
                end
            end
            EngStart: begin
                if (tick) begin
                    if (quarter_q == 2'd0) begin
                        sda_low_d = 1'b1;   // SDA falls while SCL high
                        quarter_d = 2'd1;
                    end else begin
                        scl_d     = 1'b0;
                        quarter_d = 2'd0;
                        state_d   = EngData;
                    end
                end
            end
            EngData: begin
                if (tick) begin
                    quarter_d = quarter_q + 1'b1;
                    unique case (quarter_q)
                        2'd0: sda_low_d = ack_bit ? 1'b0 : ~shift_q[23];
                        2'd1: scl_d = 1'b1;
                        2'd2: begin
                            if (ack_bit && sda_sync_q) begin
                                nack_d = 1'b1;
                            end
                        end
                        2'd3: begin
                            scl_d = 1'b0;
                            if (ack_bit) begin
                                bit_d = 4'd0;
                                if (byte_q == 2'd2) begin
                                    state_d = EngStop;
                                end else begin
                                    byte_d = byte_q + 1'b1;
                                end
                            end else begin
                                bit_d   = bit_q + 1'b1;
                                shift_d = {shift_q[22:0], 1'b0};
                            end
                        end
                        default: ;
                    endcase
                end
            end
            EngStop: begin
                if (tick) begin
                    quarter_d = quarter_q + 1'b1;
                    unique case (quarter_q)
                        2'd0: sda_low_d = 1'b1;
                        2'd1: scl_d = 1'b1;
                        2'd2: sda_low_d = 1'b0;   // SDA rises while SCL high
                        2'd3: state_d = EngIdle;
                        default: ;
                    endcase
                end
            end
            default: state_d = EngIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= EngIdle;
            cnt_q      <= '0;
            quarter_q  <= 2'd0;
            bit_q      <= 4'd0;
            byte_q     <= 2'd0;
            shift_q    <= '0;
            scl_q      <= 1'b1;
            sda_low_q  <= 1'b0;
            nack_q     <= 1'b0;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quarter_q  <= quarter_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            scl_q      <= scl_d;
            sda_low_q  <= sda_low_d;
            nack_q     <= nack_d;
            sda_meta_q <= sda_in;
            sda_sync_q <= sda_meta_q;
        end
    end

    assign busy    = (state_q != EngIdle);
    assign nack    = nack_q;
    assign scl     = scl_q;
    assign sda_low = sda_low_q;

endmodule

// File: rtl/codec_config_seq.sv
// codec_config_seq: programs an audio codec over I2C from a fixed power-up table and
// services headphone volume updates (R2 then R3) afterwards.
// Ports:
//   clk, reset_n - system clock, synchronous active-low reset
//   start        - pulse: write the whole init table (ignored while busy)
//   vol_req      - request a volume write; held pending while busy, latest vol_data wins
//   vol_data     - 7-bit headphone volume code
//   vol_ack      - one-cycle pulse when both volume words were acknowledged
//   busy         - sequencer not idle
//   done         - init table finished; held until reset or the next start
//   error        - sticky: a word ran out of retries; cleared by start or reset
//   I2C_SCLK     - push-pull SCL
//   I2C_SDAT     - open-drain SDA
module codec_config_seq
    import codec_cfg_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned I2C_HZ    = 100000,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       vol_req,
    input  logic [6:0] vol_data,
    output logic       vol_ack,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       I2C_SCLK,
    inout  wire        I2C_SDAT
);

    localparam int unsigned DIV     = CLK_HZ / (4 * I2C_HZ);
    localparam int unsigned DivSafe = (DIV == 0) ? 1 : DIV;
    localparam int unsigned RetryW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
    localparam logic [IDX_W-1:0]  IdxLast  = IDX_W'(TABLE_LEN - 1);

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic              vol_mode_q, vol_mode_d;
    logic              vol_step_q, vol_step_d;
    logic [6:0]        vol_cur_q, vol_cur_d;
    logic              vol_pend_q, vol_pend_d;
    logic [6:0]        vol_pend_data_q, vol_pend_data_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              vol_ack_q, vol_ack_d;

    logic        eng_go;
    logic        eng_busy;
    logic        eng_nack;
    logic        sda_low;
    logic [15:0] cur_word;

    always_comb begin
        if (vol_mode_q) begin
            cur_word = vol_word(vol_step_q ? REG_R3 : REG_R2, vol_cur_q);
        end else begin
            cur_word = INIT_TABLE[idx_q];
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        retry_d         = retry_q;
        vol_mode_d      = vol_mode_q;
        vol_step_d      = vol_step_q;
        vol_cur_d       = vol_cur_q;
        vol_pend_d      = vol_pend_q;
        vol_pend_data_d = vol_pend_data_q;
        done_d          = done_q;
        error_d         = error_q;
        vol_ack_d       = 1'b0;
        eng_go          = 1'b0;

        // Requests are latched in every state; accepting one below consumes it
        if (vol_req) begin
            vol_pend_d      = 1'b1;
            vol_pend_data_d = vol_data;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StLoad;
                    idx_d      = '0;
                    retry_d    = '0;
                    vol_mode_d = 1'b0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                end else if (vol_pend_d) begin
                    state_d    = StVol;
                    vol_cur_d  = vol_pend_data_d;
                    vol_pend_d = 1'b0;
                end
            end
            StVol: begin
                vol_mode_d = 1'b1;
                vol_step_d = 1'b0;
                retry_d    = '0;
                state_d    = StLoad;
            end
            StLoad: begin
                eng_go  = 1'b1;
                state_d = StXfer;
            end
            StXfer: begin
                if (!eng_busy) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (!eng_nack) begin
                    state_d = StNext;
                end else if (retry_q < RetryMax) begin
                    retry_d = retry_q + 1'b1;
                    state_d = StLoad;
                end else begin
                    state_d = StFail;
                end
            end
            StNext: begin
                retry_d = '0;
                if (vol_mode_q) begin
                    if (!vol_step_q) begin
                        vol_step_d = 1'b1;
                        state_d    = StLoad;
                    end else begin
                        vol_ack_d = 1'b1;
                        state_d   = StIdle;
                    end
                end else if (idx_q == IdxLast) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StLoad;
                end
            end
            StFail: begin
                error_d = 1'b1;
                done_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            idx_q           <= '0;
            retry_q         <= '0;
            vol_mode_q      <= 1'b0;
            vol_step_q      <= 1'b0;
            vol_cur_q       <= '0;
            vol_pend_q      <= 1'b0;
            vol_pend_data_q <= '0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            vol_ack_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            retry_q         <= retry_d;
            vol_mode_q      <= vol_mode_d;
            vol_step_q      <= vol_step_d;
            vol_cur_q       <= vol_cur_d;
            vol_pend_q      <= vol_pend_d;
            vol_pend_data_q <= vol_pend_data_d;
            done_q          <= done_d;
            error_q         <= error_d;
            vol_ack_q       <= vol_ack_d;
        end
    end

    i2c_write3 #(
        .DIV(DivSafe)
    ) u_engine (
        .clk    (clk),
        .reset_n(reset_n),
        .go     (eng_go),
        .word   (cur_word),
        .busy   (eng_busy),
        .nack   (eng_nack),
        .scl    (I2C_SCLK),
        .sda_low(sda_low),
        .sda_in (I2C_SDAT)
    );

    assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign error   = error_q;
    assign vol_ack = vol_ack_q;

endmodule

// File: tb/tb_codec_config_seq.sv
// tb_codec_config_seq: bus-level slave/monitor plus a frame-list reference model.
module tb_codec_config_seq;

    localparam int MAX_RETRY = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       vol_req = 1'b0;
    logic [6:0] vol_data = 7'h00;
    logic       vol_ack, busy, done, error, scl;
    wire        sda_bus;
    logic       slave_low = 1'b0;

    pullup (sda_bus);
    assign sda_bus = slave_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    codec_config_seq #(
        .CLK_HZ   (1600000),
        .I2C_HZ   (100000),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .vol_req (vol_req),
        .vol_data(vol_data),
        .vol_ack (vol_ack),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .I2C_SCLK(scl),
        .I2C_SDAT(sda_bus)
    );

    localparam logic [15:0] TB_TABLE [10] = '{
        16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
        16'h0812, 16'h0A06, 16'h0C00, 16'h0E01, 16'h1201
    };

    int vectors = 0;
    int miscompares = 0;

    // Slave/monitor state
    int          start_cnt = 0;
    int          ack_cnt = 0;
    int          bitpos = 0;
    int          nbytes = 0;
    int          frame_no = 0;
    bit          in_frame = 1'b0;
    logic [7:0]  cur_byte = 8'h00;
    logic [7:0]  fr [3];
    logic [23:0] frames [$];
    bit          nack_all = 1'b0;
    int          nack_lo = 0;
    int          nack_hi = 0;

    // Reference model state
    logic [15:0] job [$];
    logic [23:0] exp_fr [$];
    bit          exp_fail;

    initial begin : monitor
        logic ps, pd, s, d;
        ps = 1'b1;
        pd = 1'b1;
        forever begin
            @(negedge clk);
            s = scl;
            d = sda_bus;
            if (vol_ack === 1'b1) ack_cnt++;
            if (!reset_n) begin
                in_frame  = 1'b0;
                slave_low = 1'b0;
            end else if (ps && s && pd && !d) begin
                in_frame = 1'b1;
                bitpos   = 0;
                nbytes   = 0;
                frame_no = start_cnt;
                start_cnt++;
            end else if (ps && s && !pd && d) begin
                if (in_frame && nbytes == 3) frames.push_back({fr[0], fr[1], fr[2]});
                in_frame = 1'b0;
            end else if (in_frame && !ps && s) begin
                if (bitpos < 8) cur_byte = {cur_byte[6:0], d};
                bitpos++;
            end else if (in_frame && ps && !s) begin
                if (bitpos == 8) begin
                    slave_low = !(nack_all ||
                                  (nbytes == 0 && frame_no >= nack_lo && frame_no < nack_hi));
                end else if (bitpos == 9) begin
                    slave_low = 1'b0;
                    if (nbytes < 3) fr[nbytes] = cur_byte;
                    nbytes++;
                    bitpos = 0;
                end
            end
            ps = s;
            pd = d;
        end
    end

    function automatic bit nacked(input int f);
        return nack_all || (f >= nack_lo && f < nack_hi);
    endfunction

    // Expected frame list: each word is retried after a NACK up to MAX_RETRY times
    task automatic model_run(input int first);
        int f;
        f = first;
        exp_fr.delete();
        exp_fail = 1'b0;
        for (int w = 0; w < job.size() && !exp_fail; w++) begin
            int attempts;
            bit acked;
            attempts = 0;
            acked = 1'b0;
            while (!acked && !exp_fail) begin
                exp_fr.push_back({8'h34, job[w]});
                acked = !nacked(f);
                f++;
                attempts++;
                if (!acked && attempts > MAX_RETRY) exp_fail = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_frames(input int base, input string tag);
        check({tag, " frame count"}, 32'(frames.size() - base), 32'(exp_fr.size()));
        for (int i = 0; i < exp_fr.size() && base + i < frames.size(); i++) begin
            check($sformatf("%s frame %0d", tag, i), 32'(frames[base + i]), 32'(exp_fr[i]));
        end
    endtask

    task automatic wait_busy(input logic level, input int maxc, input string tag);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (busy === level) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL %s timeout: busy=%b, wanted %b", tag, busy, level);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_vol(input logic [6:0] v);
        @(negedge clk);
        vol_req  = 1'b1;
        vol_data = v;
        @(negedge clk);
        vol_req  = 1'b0;
    endtask

    task automatic load_table_job();
        job.delete();
        for (int i = 0; i < 10; i++) job.push_back(TB_TABLE[i]);
    endtask

    task automatic run_vol(input logic [6:0] v, input int nacks, input string tag);
        int base, s0, a0;
        base = frames.size();
        s0 = start_cnt;
        a0 = ack_cnt;
        nack_lo = s0;
        nack_hi = s0 + nacks;
        job.delete();
        job.push_back(16'h0580 | {9'b0, v});
        job.push_back(16'h0780 | {9'b0, v});
        model_run(s0);
        pulse_vol(v);
        wait_busy(1'b0, 4000, tag);
        repeat (3) @(negedge clk);
        check_frames(base, tag);
        check({tag, " vol_ack"}, 32'(ack_cnt - a0), exp_fail ? 32'd0 : 32'd1);
        nack_lo = 0;
        nack_hi = 0;
    endtask

    typedef struct {
        logic [6:0]  vol;
        int          nacks;
        logic [15:0] exp_first;
        int          exp_frames;
        bit          exp_ack;
        bit          exp_err;
    } vol_vec_t;

    vol_vec_t vv [4];

    initial begin : test
        int base, s0, a0, n;
        logic [6:0] v;

        vv[0] = '{7'h00, 0, 16'h0580, 2, 1'b1, 1'b0};
        vv[1] = '{7'h7F, 0, 16'h05FF, 2, 1'b1, 1'b0};
        vv[2] = '{7'h2A, 2, 16'h05AA, 4, 1'b1, 1'b0};
        vv[3] = '{7'h11, 4, 16'h0591, 4, 1'b0, 1'b1};

        // Reset and idle bus
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle scl", 32'(scl), 32'd1);
        check("idle sda released", 32'(sda_bus), 32'd1);
        check("idle busy", 32'(busy), 32'd0);
        check("idle done", 32'(done), 32'd0);
        check("idle error", 32'(error), 32'd0);
        check("idle vol_ack", 32'(vol_ack), 32'd0);

        // Full init with ACKing slave; a second start mid-run must be ignored
        base = frames.size();
        s0 = start_cnt;
        load_table_job();
        model_run(s0);
        pulse_start();
        repeat (1000) @(negedge clk);
        pulse_start();
        wait_busy(1'b0, 10000, "init");
        if (frames.size() > base) check("init first frame", 32'(frames[base]), 32'h341E00);
        check_frames(base, "init");
        check("init done", 32'(done), 32'd1);
        check("init busy", 32'(busy), 32'd0);
        check("init error", 32'(error), 32'd0);

        // Address NACK twice on word 3
        base = frames.size();
        s0 = start_cnt;
        nack_lo = s0 + 3;
        nack_hi = s0 + 5;
        load_table_job();
        model_run(s0);
        pulse_start();
        wait_busy(1'b0, 12000, "retry");
        check_frames(base, "retry");
        check("retry done", 32'(done), 32'd1);
        check("retry error", 32'(error), 32'd0);
        nack_lo = 0;
        nack_hi = 0;

        // Volume requests during init: latest data wins, serviced after done
        base = frames.size();
        s0 = start_cnt;
        a0 = ack_cnt;
        load_table_job();
        job.push_back(16'h05E0);
        job.push_back(16'h07E0);
        model_run(s0);
        pulse_start();
        repeat (300) @(negedge clk);
        pulse_vol(7'h79);
        repeat (1500) @(negedge clk);
        pulse_vol(7'h60);
        wait_busy(1'b0, 10000, "vol pend init");
        check("vol pend done", 32'(done), 32'd1);
        wait_busy(1'b1, 20, "vol pend launch");
        wait_busy(1'b0, 4000, "vol pend run");
        repeat (3) @(negedge clk);
        check_frames(base, "vol pend");
        check("vol pend ack count", 32'(ack_cnt - a0), 32'd1);

        // Randomized volume writes with a few address NACKs
        for (int k = 0; k < 4; k++) begin
            v = 7'($urandom_range(0, 127));
            n = int'($urandom_range(0, 2));
            run_vol(v, n, $sformatf("rand%0d", k));
            check($sformatf("rand%0d error", k), 32'(error), 32'd0);
        end

        // Table-driven volume vectors (last one exhausts retries)
        foreach (vv[i]) begin
            base = frames.size();
            a0 = ack_cnt;
            run_vol(vv[i].vol, vv[i].nacks, $sformatf("vec%0d", i));
            check($sformatf("vec%0d frames", i), 32'(frames.size() - base), 32'(vv[i].exp_frames));
            if (frames.size() > base) begin
                check($sformatf("vec%0d first word", i), 32'(frames[base][15:0]),
                      32'(vv[i].exp_first));
            end
            check($sformatf("vec%0d ack", i), 32'(ack_cnt - a0), 32'(vv[i].exp_ack));
            check($sformatf("vec%0d error", i), 32'(error), 32'(vv[i].exp_err));
        end

        // Reset mid-byte of word 5, then restart from entry 0
        base = frames.size();
        pulse_start();
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (frames.size() >= base + 5 && in_frame && nbytes == 1 && bitpos == 4) break;
        end
        check("midreset reached word5", 32'(frames.size() - base), 32'd5);
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset scl", 32'(scl), 32'd1);
        check("midreset sda", 32'(sda_bus), 32'd1);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset no stop", 32'(frames.size() - base), 32'd5);
        base = frames.size();
        s0 = start_cnt;
        load_table_job();
        model_run(s0);
        pulse_start();
        wait_busy(1'b0, 10000, "restart");
        if (frames.size() > base) check("restart first frame", 32'(frames[base]), 32'h341E00);
        check_frames(base, "restart");
        check("restart done", 32'(done), 32'd1);

        // Slave NACKs everything
        base = frames.size();
        s0 = start_cnt;
        nack_all = 1'b1;
        load_table_job();
        model_run(s0);
        pulse_start();
        wait_busy(1'b0, 6000, "nackall");
        check_frames(base, "nackall");
        check("nackall error", 32'(error), 32'd1);
        check("nackall done", 32'(done), 32'd0);
        check("nackall busy", 32'(busy), 32'd0);
        nack_all = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
